ftw_sweep_ctrl: RTL and testbench
=================================

Name: ftw_sweep_ctrl

Overview:
Sequencer for the DDFS phase accumulator. It programs the frequency tuning word (FTW) over time so the synthesiser produces chirps and FSK-style sweeps. The FTW is stepped once per time-base tick, from a start word to a stop word. Modes are single-shot, sawtooth repeat and triangle. The block drives the accumulator's `ftw` and `enable` inputs and is paced by the time-base generator's tick output `q`.

Parameters:
- `W`, 16, width of the FTW and of all config words.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `tick`  in  1  step strobe from time-base generator, one-cycle pulse
- `start`  in  1  begin sweep; sampled only in IDLE
- `abort`  in  1  stop immediately; highest priority
- `cfg_start_ftw`  in  W  first FTW of the sweep
- `cfg_stop_ftw`  in  W  final FTW of the sweep
- `cfg_step`  in  W  FTW increment magnitude per tick
- `cfg_mode`  in  2  00 single, 01 sawtooth, 10 triangle, 11 reserved
- `ftw`  out  W  tuning word to phase accumulator
- `acc_enable`  out  1  phase-accumulator enable
- `busy`  out  1  high in RUN and END
- `done`  out  1  one-cycle pulse at single-shot completion
- `err`  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE.
  - `ftw`, `acc_enable`, `busy`, `done`, `err` and all latched config registers = 0.
  - Direction register = up.
  - Reset mid-sweep aborts with no `done`.
- States: IDLE, RUN, END. All outputs are registered.
- IDLE:
  - `acc_enable` = 0, `busy` = 0; `ftw` holds its last value.
  - `start` = 1 with `cfg_step` = 0 or `cfg_mode` = 11: `err` pulses next cycle; state stays IDLE.
  - Otherwise `start` = 1 in cycle N. In cycle N+1:
    - `ftw` = `cfg_start_ftw`, `busy` = 1, `acc_enable` = 1, state = RUN.
    - `cfg_start_ftw`, `cfg_stop_ftw`, `cfg_step` and `cfg_mode` are latched; later changes to the inputs are ignored until IDLE.
    - Direction = up if `cfg_start_ftw` <= `cfg_stop_ftw` (unsigned), else down.
  - A `tick` in the start cycle is ignored.
- RUN, on `tick` (update visible the cycle after the tick):
  - Up: `next` = `ftw` + `step`, computed in W+1 bits. If the carry is set or `next` >= stop, then `ftw` <= stop and state = END. Else `ftw` <= `next`.
  - Down: if `ftw` < `step` (borrow) or `ftw` − `step` <= stop, then `ftw` <= stop and state = END. Else `ftw` <= `ftw` − `step`.
  - `ftw` never wraps. Overshoot is clipped to the stop word exactly.
  - start == stop: the first tick enters END with `ftw` unchanged.
- END, dwell at the stop word for one tick period, then on `tick`:
  - Single: state = IDLE, `done` = 1 for one cycle, `busy` = 0, `acc_enable` = 0; `ftw` holds the stop word.
  - Sawtooth: `ftw` <= latched start, state = RUN.
  - Triangle: swap the latched start and stop, invert direction, state = RUN, `ftw` unchanged. Stepping resumes on the next tick.
- `abort`:
  - In any state, next cycle: state = IDLE, `ftw` = 0, `acc_enable` = 0, `busy` = 0, no `done`.
  - `abort` beats a simultaneous `tick` or `start`.
- Ticks arriving in IDLE are ignored.
- Ticks on consecutive cycles are each honoured; no minimum spacing is required.

Test Plan:
- Single up: start=100, stop=130, step=10, mode=00.
  → `ftw` is 100 after start, then 110, 120, 130 after ticks 1–3.
  → Tick 4: `done` pulses once; `busy` and `acc_enable` go 0; `ftw` stays 130.
- Clip and overflow:
  - start=100, stop=125, step=10 → 100, 110, 120, 125.
  - start=0xFFF0, stop=0xFFFF, step=0x20 → first tick gives 0xFFFF (no wrap to 0x0010).
- Down with borrow: start=5, stop=0, step=3 → 5, 2, 0, then END.
- Triangle: start=0, stop=20, step=10, mode=10.
  → Ticks 1–7 give `ftw` 10, 20, 20 (flip), 10, 0, 0 (flip), 10.
  → `busy` stays 1 and `done` never pulses.
- Sawtooth with abort: start=0, stop=30, step=10, mode=01.
  → After stop, the END tick reloads 0.
  → `abort` asserted in the same cycle as a tick: next cycle `ftw`=0, `busy`=0, no `done`.
  → A subsequent `start` restarts normally.
- Rejects and reset:
  - `start` with step=0 → one `err` pulse, state stays IDLE.
  - `start` with mode=11 → one `err` pulse, state stays IDLE.
  - `start` asserted while busy → no effect.
  - `reset_n` low mid-RUN → outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ftw_sweep_ctrl_if.sv
// Control, configuration and accumulator-drive bundle for the FTW sweep sequencer.
// The master side drives the strobes and config; the slave side is the sequencer itself.
interface ftw_sweep_ctrl_if #(
  parameter int W = 16
);
  // tick, start and abort are single-cycle strobes sampled on the rising clock.
  // Nothing is held back: a strobe is consumed in the cycle it is high or it is dropped.
  logic         tick;
  logic         start;
  logic         abort;
  logic [W-1:0] cfg_start_ftw;
  logic [W-1:0] cfg_stop_ftw;
  logic [W-1:0] cfg_step;
  logic [1:0]   cfg_mode;
  logic [W-1:0] ftw;
  logic         acc_enable;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   dbg_state;

  modport master (
    output tick, start, abort, cfg_start_ftw, cfg_stop_ftw, cfg_step, cfg_mode,
    input  ftw, acc_enable, busy, done, err, dbg_state
  );

  modport slave (
    input  tick, start, abort, cfg_start_ftw, cfg_stop_ftw, cfg_step, cfg_mode,
    output ftw, acc_enable, busy, done, err, dbg_state
  );
endinterface

// File: rtl/ftw_sweep_ctrl.sv
// Steps the DDFS tuning word from a start to a stop word once per time-base tick,
// in single-shot, sawtooth or triangle mode, clipping overshoot to the stop word.
module ftw_sweep_ctrl #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  ftw_sweep_ctrl_if.slave  sw
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;

  localparam logic [1:0] M_SINGLE = 2'b00;
  localparam logic [1:0] M_SAW    = 2'b01;
  localparam logic [1:0] M_TRI    = 2'b10;
  localparam logic [1:0] M_RSVD   = 2'b11;

  logic [1:0]   r_state;
  logic [W-1:0] r_ftw;
  logic         r_en;
  logic         r_busy;
  logic         r_done;
  logic         r_err;
  logic [W-1:0] r_start;
  logic [W-1:0] r_stop;
  logic [W-1:0] r_step;
  logic [1:0]   r_mode;
  logic         r_dir_up;

  logic [W:0]   w_sum;
  logic [W-1:0] w_diff;
  logic         w_up_end;
  logic         w_dn_end;
  logic         w_reject;

  // Up uses the carry bit, down the borrow, so the word can never wrap past stop.
  assign w_sum    = {1'b0, r_ftw} + {1'b0, r_step};
  assign w_diff   = r_ftw - r_step;
  assign w_up_end = w_sum[W] || (w_sum[W-1:0] >= r_stop);
  assign w_dn_end = (r_ftw < r_step) || (w_diff <= r_stop);
  assign w_reject = (sw.cfg_step == '0) || (sw.cfg_mode == M_RSVD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ftw    <= '0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_start  <= '0;
      r_stop   <= '0;
      r_step   <= '0;
      r_mode   <= M_SINGLE;
      r_dir_up <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (sw.abort) begin
        r_state <= S_IDLE;
        r_ftw   <= '0;
        r_en    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (sw.start) begin
              if (w_reject) begin
                r_err <= 1'b1;
              end else begin
                r_start  <= sw.cfg_start_ftw;
                r_stop   <= sw.cfg_stop_ftw;
                r_step   <= sw.cfg_step;
                r_mode   <= sw.cfg_mode;
                r_dir_up <= (sw.cfg_start_ftw <= sw.cfg_stop_ftw);
                r_ftw    <= sw.cfg_start_ftw;
                r_en     <= 1'b1;
                r_busy   <= 1'b1;
                r_state  <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (sw.tick) begin
              if (r_dir_up ? w_up_end : w_dn_end) begin
                r_ftw   <= r_stop;
                r_state <= S_END;
              end else begin
                r_ftw <= r_dir_up ? w_sum[W-1:0] : w_diff;
              end
            end
          end
          S_END: begin
            if (sw.tick) begin
              case (r_mode)
                M_SAW: begin
                  r_ftw   <= r_start;
                  r_state <= S_RUN;
                end
                M_TRI: begin
                  // Reverse in place: the stop word becomes the new origin.
                  r_start  <= r_stop;
                  r_stop   <= r_start;
                  r_dir_up <= !r_dir_up;
                  r_state  <= S_RUN;
                end
                default: begin
                  r_done  <= 1'b1;
                  r_en    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end
              endcase
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign sw.ftw        = r_ftw;
  assign sw.acc_enable = r_en;
  assign sw.busy       = r_busy;
  assign sw.done       = r_done;
  assign sw.err        = r_err;
  assign sw.dbg_state  = r_state;
endmodule

// File: tb/tb_ftw_sweep_ctrl.sv
// Directed bench for ftw_sweep_ctrl: the driver queues hand-computed outputs tagged
// with the cycle they must appear in; a negedge monitor pops and compares them.
module tb_ftw_sweep_ctrl;
  localparam int W  = 16;
  localparam int EW = 16 + W + 4;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_pass;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  string         cur_name;

  ftw_sweep_ctrl_if #(.W(W)) bus();

  ftw_sweep_ctrl #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw      (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // monitor / scoreboard
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][EW-1 -: 16] <= cyc[15:0]) begin
      logic [EW-1:0] e;
      logic [W+3:0]  act;
      string         nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {bus.ftw, bus.busy, bus.acc_enable, bus.done, bus.err};
      n_checks++;
      if (e[EW-1 -: 16] != cyc[15:0]) begin
        $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", nm, e[EW-1 -: 16], cyc);
      end else if (act !== e[W+3:0]) begin
        $display("FAIL %s @cyc %0d: got ftw=%h busy=%b en=%b done=%b err=%b, want ftw=%h busy=%b en=%b done=%b err=%b",
                 nm, cyc, act[W+3:4], act[3], act[2], act[1], act[0],
                 e[W+3:4], e[3], e[2], e[1], e[0]);
      end else begin
        n_pass++;
      end
    end
  end

  // driver tasks
  task automatic set_cfg(input logic [W-1:0] s, input logic [W-1:0] p,
                         input logic [W-1:0] st, input logic [1:0] m);
    bus.cfg_start_ftw = s;
    bus.cfg_stop_ftw  = p;
    bus.cfg_step      = st;
    bus.cfg_mode      = m;
  endtask

  // Drive one cycle of strobes and queue the outputs expected after that edge.
  task automatic cyc_io(input logic tk, input logic st, input logic ab,
                        input logic [W-1:0] f, input logic b, input logic en,
                        input logic d, input logic er);
    int tag;
    bus.tick  = tk;
    bus.start = st;
    bus.abort = ab;
    tag = cyc + 1;
    exp_q.push_back({tag[15:0], f, b, en, d, er});
    name_q.push_back(cur_name);
    @(posedge clk);
    #1;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic check_now(input string nm, input logic [W+5:0] want);
    logic [W+5:0] act;
    act = {bus.ftw, bus.busy, bus.acc_enable, bus.done, bus.err, bus.dbg_state};
    n_checks++;
    if (act !== want)
      $display("FAIL %s: got %h, want %h", nm, act, want);
    else
      n_pass++;
  endtask

  task automatic drain(input string nm);
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL %s: %0d expectations never checked", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0;
    reset_n = 1'b0;
    bus.tick = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    set_cfg(16'd0, 16'd0, 16'd0, 2'b00);
    #23;
    check_now("reset_state", '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    cur_name = "single_up";
    set_cfg(16'd100, 16'd130, 16'd10, 2'b00);
    cyc_io(0, 1, 0, 16'd100, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd110, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd120, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd130, 1, 1, 0, 0);
    cyc_io(0, 0, 0, 16'd130, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd130, 0, 0, 1, 0);
    cyc_io(0, 0, 0, 16'd130, 0, 0, 0, 0);
    cur_name = "idle_tick";
    cyc_io(1, 0, 0, 16'd130, 0, 0, 0, 0);

    cur_name = "clip";
    set_cfg(16'd100, 16'd125, 16'd10, 2'b00);
    cyc_io(0, 1, 0, 16'd100, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd110, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd120, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd125, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd125, 0, 0, 1, 0);

    cur_name = "overflow";
    set_cfg(16'hFFF0, 16'hFFFF, 16'h0020, 2'b00);
    cyc_io(0, 1, 0, 16'hFFF0, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'hFFFF, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'hFFFF, 0, 0, 1, 0);

    cur_name = "down_borrow";
    set_cfg(16'd5, 16'd0, 16'd3, 2'b00);
    cyc_io(1, 1, 0, 16'd5, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd2, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd0, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd0, 0, 0, 1, 0);

    cur_name = "start_eq_stop";
    set_cfg(16'd77, 16'd77, 16'd4, 2'b00);
    cyc_io(0, 1, 0, 16'd77, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd77, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd77, 0, 0, 1, 0);

    cur_name = "triangle";
    set_cfg(16'd0, 16'd20, 16'd10, 2'b10);
    cyc_io(0, 1, 0, 16'd0, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd10, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd20, 1, 1, 0, 0);
    cyc_io(0, 0, 0, 16'd20, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd20, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd10, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd0, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd0, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd10, 1, 1, 0, 0);
    cyc_io(0, 0, 1, 16'd0, 0, 0, 0, 0);

    cur_name = "sawtooth";
    set_cfg(16'd0, 16'd30, 16'd10, 2'b01);
    cyc_io(0, 1, 0, 16'd0, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd10, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd20, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd30, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd0, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd10, 1, 1, 0, 0);
    cur_name = "abort_with_tick";
    cyc_io(1, 0, 1, 16'd0, 0, 0, 0, 0);
    cyc_io(0, 0, 0, 16'd0, 0, 0, 0, 0);
    cur_name = "restart";
    cyc_io(0, 1, 0, 16'd0, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd10, 1, 1, 0, 0);
    cur_name = "start_while_busy";
    set_cfg(16'd500, 16'd600, 16'd1, 2'b00);
    cyc_io(0, 1, 0, 16'd10, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd20, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd30, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd0, 1, 1, 0, 0);
    cur_name = "abort_in_run";
    cyc_io(0, 0, 1, 16'd0, 0, 0, 0, 0);
    cur_name = "abort_beats_start";
    cyc_io(0, 1, 1, 16'd0, 0, 0, 0, 0);
    cyc_io(0, 0, 0, 16'd0, 0, 0, 0, 0);

    cur_name = "reject_step0";
    set_cfg(16'd10, 16'd50, 16'd0, 2'b00);
    cyc_io(0, 1, 0, 16'd0, 0, 0, 0, 1);
    cyc_io(1, 0, 0, 16'd0, 0, 0, 0, 0);
    cur_name = "reject_mode3";
    set_cfg(16'd10, 16'd50, 16'd5, 2'b11);
    cyc_io(0, 1, 0, 16'd0, 0, 0, 0, 1);
    cyc_io(0, 0, 0, 16'd0, 0, 0, 0, 0);

    cur_name = "pre_reset_run";
    set_cfg(16'd100, 16'd200, 16'd10, 2'b00);
    cyc_io(0, 1, 0, 16'd100, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd110, 1, 1, 0, 0);
    drain("pre_reset_drain");
    reset_n = 1'b0;
    #2;
    check_now("async_reset_mid_run", '0);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cur_name = "after_reset";
    cyc_io(0, 1, 0, 16'd100, 1, 1, 0, 0);
    cyc_io(1, 0, 0, 16'd110, 1, 1, 0, 0);

    drain("final_drain");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
